// File: rtl/lcg_pkg.sv
// Shared constants, output-mode enum and helpers for the multi-channel LCG.
package lcg_pkg;

  // Widest state the generator supports; MULTIPLIER/INCREMENT are given at this width.
  localparam int          LCG_MAX_W    = 64;
  localparam logic [63:0] LCG_MULT_DEF = 64'h5851F42D4C957F2D;
  localparam logic [63:0] LCG_INC_DEF  = 64'h14057B7EF767814F;

  typedef enum logic {
    RAW  = 1'b0,
    FOLD = 1'b1
  } out_mode_e;

  // Fold the upper half onto the lower half; w is the live width of s.
  function automatic logic [LCG_MAX_W-1:0] fold(input logic [LCG_MAX_W-1:0] s, input int w);
    return s ^ (s >> (w / 2));
  endfunction

  // Channel index width; a single channel still needs a 1-bit select port.
  function automatic int chan_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lcg_step.sv
// One LCG step: next = s*MULTIPLIER + inc, everything truncated to WIDTH.
module lcg_step
  import lcg_pkg::*;
#(
  parameter int          WIDTH      = 64,
  parameter logic [63:0] MULTIPLIER = LCG_MULT_DEF
) (
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] inc,
  output logic [WIDTH-1:0] nxt
);

  localparam logic [WIDTH-1:0] MULT_W = MULTIPLIER[WIDTH-1:0];

  // WIDTH-bit context: the product's upper half is discarded by construction.
  assign nxt = s * MULT_W + inc;

endmodule

// File: rtl/lcg_prng_mc.sv
// Multi-channel LCG PRNG: CHANNELS independent states served round-robin
// into one valid/ready output register, with per-channel reseeding.
module lcg_prng_mc
  import lcg_pkg::*;
#(
  parameter int          WIDTH      = 64,
  parameter int          CHANNELS   = 2,
  parameter logic [63:0] MULTIPLIER = LCG_MULT_DEF,
  parameter logic [63:0] INCREMENT  = LCG_INC_DEF,
  parameter int          OUT_MODE   = 0,
  localparam int         CH_W       = chan_w(CHANNELS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             seed_valid,
  output logic             seed_ready,
  input  logic [CH_W-1:0]  seed_chan,
  input  logic [WIDTH-1:0] seed_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CH_W-1:0]  out_chan
);

  localparam logic [WIDTH-1:0] INC_W    = INCREMENT[WIDTH-1:0];
  localparam logic [CH_W:0]    CH_LIM   = (CH_W+1)'(CHANNELS);
  localparam logic [CH_W-1:0]  PTR_LAST = CH_W'(CHANNELS - 1);
  localparam bit               DO_FOLD  = (OUT_MODE == int'(FOLD));

  logic [CHANNELS-1:0][WIDTH-1:0] st;
  logic [CH_W-1:0]                ptr;
  logic [WIDTH-1:0]               cur, inc_cur, nxt, sample;
  logic                           seed_hit, free;

  assign seed_ready = 1'b1;

  // Out-of-range seed writes are dropped and do not disturb the stream.
  assign seed_hit = seed_valid && ({1'b0, seed_chan} < CH_LIM);
  assign free     = !out_valid || out_ready;

  // Served channel's state, its odd increment, and the emitted (pre-step) value.
  always_comb begin
    cur     = st[ptr];
    inc_cur = INC_W + (WIDTH'(ptr) << 1);
    sample  = DO_FOLD ? WIDTH'(fold(LCG_MAX_W'(cur), WIDTH)) : cur;
  end

  // Single shared step unit, fed by the round-robin pointer.
  lcg_step #(
    .WIDTH      (WIDTH),
    .MULTIPLIER (MULTIPLIER)
  ) u_step (
    .s   (cur),
    .inc (inc_cur),
    .nxt (nxt)
  );

  // State array, pointer and output register: seed beats fill, fill beats drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) st[c] <= WIDTH'(c);
      ptr       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (seed_hit) begin
      // Flush: a pending sample may predate the new seed, so drop it.
      st[seed_chan] <= seed_data;
      out_valid     <= 1'b0;
    end else if (en && free) begin
      out_data  <= sample;
      out_chan  <= ptr;
      out_valid <= 1'b1;
      st[ptr]   <= nxt;
      ptr       <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
    end else if (!en && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lcg_prng_mc.sv
// Scoreboard bench: three instances (2ch raw, 2ch fold, 3ch raw) share en/out_ready.
module tb_lcg_prng_mc;
  import lcg_pkg::*;

  localparam logic [63:0] M   = 64'h5851F42D4C957F2D;
  localparam logic [63:0] INC = 64'h14057B7EF767814F;
  localparam int          ND  = 3;

  logic        clk = 1'b0;
  logic        rst, en, out_ready, sv_a, sv_b;
  logic [1:0]  sch;
  logic [63:0] sdat;

  logic        sr0, sr1, sr2, ov0, ov1, ov2;
  logic [63:0] od0, od1, od2;
  logic        oc0, oc1;
  logic [1:0]  oc2;

  logic        ov [ND];
  logic [63:0] od [ND];
  logic [1:0]  oc [ND];
  logic        sr [ND];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lcg_prng_mc #(.WIDTH(64), .CHANNELS(2), .OUT_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .seed_valid(sv_a), .seed_ready(sr0),
    .seed_chan(sch[0:0]), .seed_data(sdat), .out_valid(ov0), .out_ready(out_ready),
    .out_data(od0), .out_chan(oc0));

  lcg_prng_mc #(.WIDTH(64), .CHANNELS(2), .OUT_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .seed_valid(sv_a), .seed_ready(sr1),
    .seed_chan(sch[0:0]), .seed_data(sdat), .out_valid(ov1), .out_ready(out_ready),
    .out_data(od1), .out_chan(oc1));

  lcg_prng_mc #(.WIDTH(64), .CHANNELS(3), .OUT_MODE(0)) dut2 (
    .clk(clk), .rst(rst), .en(en), .seed_valid(sv_b), .seed_ready(sr2),
    .seed_chan(sch), .seed_data(sdat), .out_valid(ov2), .out_ready(out_ready),
    .out_data(od2), .out_chan(oc2));

  always_comb begin
    ov[0] = ov0; ov[1] = ov1; ov[2] = ov2;
    od[0] = od0; od[1] = od1; od[2] = od2;
    oc[0] = {1'b0, oc0}; oc[1] = {1'b0, oc1}; oc[2] = oc2;
    sr[0] = sr0; sr[1] = sr1; sr[2] = sr2;
  end

  // ---------------- reference model ----------------
  // sq[m*4+c]: upcoming raw states of channel c in instance m, oldest first.
  logic [63:0] sq [ND*4][$];
  int          rr [ND];
  logic [63:0] lg_d [ND][$];
  logic [1:0]  lg_c [ND][$];

  function automatic int nch(input int m);
    return (m == 2) ? 3 : 2;
  endfunction

  function automatic logic [63:0] ref_step(input logic [63:0] s, input int c);
    return s * M + INC + 64'(2 * c);
  endfunction

  function automatic logic [63:0] ref_out(input int m, input logic [63:0] s);
    return (m == 1) ? (s ^ (s >> 32)) : s;
  endfunction

  task automatic model_seed(input int m, input int c, input logic [63:0] v);
    int k;
    k = m * 4 + c;
    sq[k].delete();
    sq[k].push_back(v);
    for (int i = 0; i < 7; i++) sq[k].push_back(ref_step(sq[k][$], c));
  endtask

  task automatic clr_log(input int m);
    lg_d[m].delete();
    lg_c[m].delete();
  endtask

  task automatic model_reset();
    for (int m = 0; m < ND; m++) begin
      rr[m] = 0;
      clr_log(m);
      for (int c = 0; c < nch(m); c++) model_seed(m, c, 64'(c));
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_log(input int m, input int idx, input int c, input logic [63:0] d);
    if (idx >= lg_d[m].size()) begin
      checks++;
      errors++;
      $display("FAIL log%0d[%0d]: got %0d samples expected more than %0d", m, idx, lg_d[m].size(), idx);
    end else begin
      chk($sformatf("log%0d[%0d].chan", m, idx), 64'(lg_c[m][idx]), 64'(c));
      chk($sformatf("log%0d[%0d].data", m, idx), lg_d[m][idx], d);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic        pv [ND];
    logic [63:0] pd [ND];
    logic [1:0]  pc [ND];
    logic        pr;
    logic [63:0] e;
    int          k;
    pr = 1'b0;
    for (int m = 0; m < ND; m++) begin pv[m] = 1'b0; pd[m] = '0; pc[m] = '0; end
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int m = 0; m < ND; m++) pv[m] = 1'b0;
      end else begin
        for (int m = 0; m < ND; m++) begin
          if (ov[m] && (!pv[m] || pr)) begin
            k = m * 4 + rr[m];
            e = sq[k].pop_front();
            if (sq[k].size() < 4) sq[k].push_back(ref_step(sq[k][$], rr[m]));
            chk($sformatf("sb%0d.chan", m), 64'(oc[m]), 64'(rr[m]));
            chk($sformatf("sb%0d.data", m), od[m], ref_out(m, e));
            lg_d[m].push_back(od[m]);
            lg_c[m].push_back(oc[m]);
            rr[m] = (rr[m] + 1) % nch(m);
          end else if (ov[m] && pv[m] && !pr) begin
            chk($sformatf("hold%0d.data", m), od[m], pd[m]);
            chk($sformatf("hold%0d.chan", m), 64'(oc[m]), 64'(pc[m]));
          end
        end
      end
      for (int m = 0; m < ND; m++) begin pv[m] = ov[m]; pd[m] = od[m]; pc[m] = oc[m]; end
      pr = out_ready;
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    en = 0; out_ready = 0; sv_a = 0; sv_b = 0;
    rst = 1;
    model_reset();
    @(posedge clk); @(posedge clk); #2;
    rst = 0;
  endtask

  // Four samples after a fresh start with en=1, out_ready=1.
  task automatic check_start();
    chk_log(0, 0, 0, 64'h0);
    chk_log(0, 1, 1, 64'h1);
    chk_log(0, 2, 0, 64'h14057B7EF767814F);
    chk_log(0, 3, 1, 64'h6C576FAC43FD007E);
    chk_log(1, 0, 0, 64'h0);
    chk_log(1, 1, 1, 64'h1);
    chk_log(1, 2, 0, 64'h14057B7EE362FA31);
    chk_log(1, 3, 1, 64'h6C576FAC2FAA6FD2);
    chk_log(2, 0, 0, 64'h0);
    chk_log(2, 1, 1, 64'h1);
    chk_log(2, 2, 2, 64'h2);
    chk_log(2, 3, 0, 64'h14057B7EF767814F);
  endtask

  initial begin
    rst = 0; en = 0; out_ready = 0; sv_a = 0; sv_b = 0; sch = 0; sdat = 0;
    model_reset();
    #1 rst = 1;
    #1;
    for (int m = 0; m < ND; m++) begin
      chk($sformatf("rst%0d.valid", m), 64'(ov[m]), 64'h0);
      chk($sformatf("rst%0d.data", m), od[m], 64'h0);
      chk($sformatf("rst%0d.chan", m), 64'(oc[m]), 64'h0);
      chk($sformatf("rst%0d.seed_ready", m), 64'(sr[m]), 64'h1);
    end

    // Free-running start: first sample one cycle after en.
    do_reset();
    en = 1; out_ready = 1;
    @(posedge clk); #1;
    for (int m = 0; m < ND; m++) chk($sformatf("lat%0d", m), 64'(ov[m]), 64'h1);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_start();

    // Asynchronous reset between edges, then restart.
    @(posedge clk); #3;
    rst = 1;
    #1;
    for (int m = 0; m < ND; m++) chk($sformatf("arst%0d.valid", m), 64'(ov[m]), 64'h0);
    model_reset();
    @(posedge clk); #3;
    rst = 0;
    repeat (4) @(posedge clk);
    @(negedge clk); #1;
    check_start();

    // Backpressure: the first sample is held for five cycles.
    do_reset();
    en = 1; out_ready = 0;
    @(posedge clk); #1;
    repeat (5) begin
      @(posedge clk); #1;
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("bp%0d.valid", m), 64'(ov[m]), 64'h1);
        chk($sformatf("bp%0d.data", m), od[m], 64'h0);
        chk($sformatf("bp%0d.chan", m), 64'(oc[m]), 64'h0);
      end
    end
    #1 out_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk_log(0, 0, 0, 64'h0);
    chk_log(0, 1, 1, 64'h1);
    chk_log(0, 2, 0, 64'h14057B7EF767814F);
    chk_log(1, 2, 0, 64'h14057B7EE362FA31);
    chk_log(2, 2, 2, 64'h2);

    // Reseed channel 1 to zero while streaming.
    do_reset();
    en = 1; out_ready = 1;
    repeat (3) @(posedge clk);
    #2;
    sv_a = 1; sch = 2'd1; sdat = 64'h0;
    @(posedge clk); #1;
    model_seed(0, 1, 64'h0);
    model_seed(1, 1, 64'h0);
    clr_log(0); clr_log(1);
    chk("seed_flush0", 64'(ov[0]), 64'h0);
    chk("seed_flush1", 64'(ov[1]), 64'h0);
    #1 sv_a = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk_log(0, 0, 1, 64'h0);
    chk_log(0, 1, 0, ref_step(INC, 0));
    chk_log(0, 2, 1, 64'h14057B7EF7678151);
    chk_log(1, 0, 1, 64'h0);
    chk_log(1, 2, 1, 64'h14057B7EE362FA2F);

    // Out-of-range seed on the 3-channel instance: no flush, stream unchanged.
    do_reset();
    en = 1; out_ready = 1;
    sv_b = 1; sch = 2'd3; sdat = {$urandom, $urandom};
    @(posedge clk); #1;
    chk("oor_noflush", 64'(ov[2]), 64'h1);
    #1 sv_b = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk_log(2, 0, 0, 64'h0);
    chk_log(2, 1, 1, 64'h1);
    chk_log(2, 2, 2, 64'h2);
    chk_log(2, 3, 0, 64'h14057B7EF767814F);

    // Randomized traffic: en, backpressure and seeds (including out-of-range).
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      en        = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      sv_a      = ($urandom_range(0, 24) == 0);
      sv_b      = ($urandom_range(0, 24) == 0);
      sch       = 2'($urandom_range(0, 3));
      sdat      = ($urandom_range(0, 3) == 0) ? 64'h0 : {$urandom, $urandom};
      @(posedge clk); #1;
      if (sv_a) begin
        model_seed(0, int'(sch[0]), sdat);
        model_seed(1, int'(sch[0]), sdat);
      end
      if (sv_b && sch != 2'd3) model_seed(2, int'(sch), sdat);
      #1;
    end
    sv_a = 0; sv_b = 0; en = 0; out_ready = 1;
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
